// File: rtl/bolme_birimi_if.sv
`default_nettype none
// ============================================================================
// Module   : bolme_birimi_if
// Purpose  : Start/valid handshake and stall bundle between the execute-stage
//            controller and the iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
interface bolme_birimi_if #(
  parameter int VERI_GENISLIGI = 32
);
  logic                      durdur_i;
  logic                      basla_i;
  logic [1:0]                kontrol_i;
  logic [VERI_GENISLIGI-1:0] deger1_i;
  logic [VERI_GENISLIGI-1:0] deger2_i;
  logic [VERI_GENISLIGI-1:0] sonuc_o;
  logic                      gecerli_o;
  logic                      mesgul_o;

  modport master (
    output durdur_i, basla_i, kontrol_i, deger1_i, deger2_i,
    input  sonuc_o, gecerli_o, mesgul_o
  );

  modport slave (
    input  durdur_i, basla_i, kontrol_i, deger1_i, deger2_i,
    output sonuc_o, gecerli_o, mesgul_o
  );
endinterface
`default_nettype wire

// File: rtl/bolme_birimi.sv
`default_nettype none
// ============================================================================
// Module   : bolme_birimi
// Purpose  : Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU), one
//            quotient bit per clock, start/valid handshake with pipeline stall.
//            Optional macro BOLME_HIZLI_EN: divide-by-zero and signed overflow
//            skip the iterations and finish one cycle after acceptance.
// Revision : 1.0 - initial release
// ============================================================================
module bolme_birimi #(
  parameter int VERI_GENISLIGI = 32
) (
  input  wire logic           clk_i,
  input  wire logic           rst_i,
  bolme_birimi_if.slave       bus
);

  localparam int c_sayac_gen = $clog2(VERI_GENISLIGI + 1);
  localparam logic [c_sayac_gen-1:0] c_sayac_bas = c_sayac_gen'(VERI_GENISLIGI);
  localparam logic [c_sayac_gen-1:0] c_sayac_bir = c_sayac_gen'(1);
  localparam logic [VERI_GENISLIGI-1:0] c_en_kucuk = {1'b1, {(VERI_GENISLIGI-1){1'b0}}};

  localparam logic [1:0] c_bosta   = 2'd0;
  localparam logic [1:0] c_hesapla = 2'd1;
  localparam logic [1:0] c_bitti   = 2'd2;

  logic [1:0]                r_durum;
  logic [1:0]                w_sonraki;
  logic [c_sayac_gen-1:0]    r_sayac;
  logic [VERI_GENISLIGI-1:0] r_kalan;
  logic [VERI_GENISLIGI-1:0] r_bolum;
  logic [VERI_GENISLIGI-1:0] r_bolen;
  logic [VERI_GENISLIGI-1:0] r_bolunen;
  logic                      r_bolum_neg;
  logic                      r_kalan_neg;
  logic                      r_kalan_sec;
  logic                      r_sifir_bolen;
  logic                      r_tasma;
  logic [VERI_GENISLIGI-1:0] r_sonuc;
  logic                      r_gecerli;

  logic                      w_isaretli;
  logic                      w_a_neg;
  logic                      w_b_neg;
  logic [VERI_GENISLIGI-1:0] w_a_buyukluk;
  logic [VERI_GENISLIGI-1:0] w_b_buyukluk;
  logic                      w_sifir_bolen;
  logic                      w_tasma;
  logic                      w_hizli;
  logic                      w_kabul;
  logic                      w_yukle;
  logic                      w_adim;
  logic                      w_bitir;
  logic                      w_mesgul;
  logic [VERI_GENISLIGI:0]   w_kaydir;
  logic [VERI_GENISLIGI:0]   w_fark;
  logic [VERI_GENISLIGI-1:0] w_yeni_kalan;
  logic [VERI_GENISLIGI-1:0] w_bolum_duz;
  logic [VERI_GENISLIGI-1:0] w_kalan_duz;
  logic [VERI_GENISLIGI-1:0] w_sonuc_son;

  // kontrol_i[0]=0 selects the signed variants, kontrol_i[1]=1 the remainder.
  assign w_isaretli    = ~bus.kontrol_i[0];
  assign w_a_neg       = w_isaretli & bus.deger1_i[VERI_GENISLIGI-1];
  assign w_b_neg       = w_isaretli & bus.deger2_i[VERI_GENISLIGI-1];
  assign w_a_buyukluk  = w_a_neg ? -bus.deger1_i : bus.deger1_i;
  assign w_b_buyukluk  = w_b_neg ? -bus.deger2_i : bus.deger2_i;
  assign w_sifir_bolen = (bus.deger2_i == '0);
  assign w_tasma       = w_isaretli & (bus.deger1_i == c_en_kucuk) & (bus.deger2_i == '1);

`ifdef BOLME_HIZLI_EN
  assign w_hizli = w_sifir_bolen | w_tasma;
`else
  assign w_hizli = 1'b0;
`endif

  // A start is refused while the previous result pulse is still on the bus.
  assign w_kabul = (r_durum == c_bosta) & bus.basla_i & ~r_gecerli & ~bus.durdur_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_durum <= c_bosta;
    end else if (!bus.durdur_i) begin
      r_durum <= w_sonraki;
    end
  end

  always_comb begin
    w_sonraki = r_durum;
    case (r_durum)
      c_bosta:   if (w_kabul) w_sonraki = w_hizli ? c_bitti : c_hesapla;
      c_hesapla: if (r_sayac == c_sayac_bir) w_sonraki = c_bitti;
      c_bitti:   w_sonraki = c_bosta;
      default:   w_sonraki = c_bosta;
    endcase
  end

  always_comb begin
    w_yukle  = 1'b0;
    w_adim   = 1'b0;
    w_bitir  = 1'b0;
    w_mesgul = 1'b0;
    case (r_durum)
      c_bosta:   w_yukle = w_kabul;
      c_hesapla: begin
        w_adim   = 1'b1;
        w_mesgul = 1'b1;
      end
      c_bitti:   begin
        w_bitir  = 1'b1;
        w_mesgul = 1'b1;
      end
      default:   w_yukle = 1'b0;
    endcase
  end

  // The running remainder is always below the divisor, so one guard bit suffices.
  assign w_kaydir     = {r_kalan, r_bolum[VERI_GENISLIGI-1]};
  assign w_fark       = w_kaydir - {1'b0, r_bolen};
  assign w_yeni_kalan = w_fark[VERI_GENISLIGI] ? w_kaydir[VERI_GENISLIGI-1:0]
                                               : w_fark[VERI_GENISLIGI-1:0];

  always_comb begin
    w_bolum_duz = r_bolum_neg ? -r_bolum : r_bolum;
    w_kalan_duz = r_kalan_neg ? -r_kalan : r_kalan;
    if (r_sifir_bolen) begin
      w_sonuc_son = r_kalan_sec ? r_bolunen : '1;
    end else if (r_tasma) begin
      w_sonuc_son = r_kalan_sec ? '0 : c_en_kucuk;
    end else begin
      w_sonuc_son = r_kalan_sec ? w_kalan_duz : w_bolum_duz;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_sayac       <= '0;
      r_kalan       <= '0;
      r_bolum       <= '0;
      r_bolen       <= '0;
      r_bolunen     <= '0;
      r_bolum_neg   <= 1'b0;
      r_kalan_neg   <= 1'b0;
      r_kalan_sec   <= 1'b0;
      r_sifir_bolen <= 1'b0;
      r_tasma       <= 1'b0;
      r_sonuc       <= '0;
      r_gecerli     <= 1'b0;
    end else if (!bus.durdur_i) begin
      r_gecerli <= 1'b0;
      if (w_yukle) begin
        r_sayac       <= c_sayac_bas;
        r_kalan       <= '0;
        r_bolum       <= w_a_buyukluk;
        r_bolen       <= w_b_buyukluk;
        r_bolunen     <= bus.deger1_i;
        r_bolum_neg   <= w_a_neg ^ w_b_neg;
        r_kalan_neg   <= w_a_neg;
        r_kalan_sec   <= bus.kontrol_i[1];
        r_sifir_bolen <= w_sifir_bolen;
        r_tasma       <= w_tasma;
      end
      if (w_adim) begin
        r_kalan <= w_yeni_kalan;
        r_bolum <= {r_bolum[VERI_GENISLIGI-2:0], ~w_fark[VERI_GENISLIGI]};
        r_sayac <= r_sayac - c_sayac_bir;
      end
      if (w_bitir) begin
        r_sonuc   <= w_sonuc_son;
        r_gecerli <= 1'b1;
      end
    end
  end

  assign bus.sonuc_o   = r_sonuc;
  assign bus.gecerli_o = r_gecerli;
  assign bus.mesgul_o  = w_mesgul;

endmodule
`default_nettype wire
